enc4to2_queue: RTL
==================

ENC4TO2_QUEUE -- requirements
Module: enc4to2_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst, rising-edge sampled.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 EN  input  1  request enable; D is ignored when EN=0.
REQ-005 D  input  4  request lines, one per source; bit 3 has the highest priority, bit 0 the lowest.
REQ-006 RDY  input  1  consumer ready; a transfer occurs on a cycle with VLD=1 and RDY=1.
REQ-007 Y  output  2  encoded index of the presented request, registered.
REQ-008 VLD  output  1  Y holds a valid request, registered.
REQ-009 PEND  output  4  pending-request register P, registered.
REQ-010 OVF  output  1  one-cycle pulse: a request arrived for a source already pending.

Function
REQ-011 The block SHALL be the encoder counterpart of the team's 2-to-4 decoder: it queues one-hot/multi-hot requests and emits 2-bit indices with a valid/ready handshake.
REQ-012 Accept term: acc = VLD & RDY; clr = acc ? onehot(Y) : 4'b0000.
REQ-013 Pending update: P_next = (P & ~clr) | (EN ? D : 4'b0000).
REQ-014 Simultaneous clear and new request on the same bit: the set wins, and the bit stays pending (request re-queued).
REQ-015 Output state: two states, IDLE (VLD=0) and PRESENT (VLD=1).
REQ-016 IDLE, or PRESENT with acc=1: compute Pa = P & ~clr.
- If Pa != 0: next state PRESENT, Y_next = index of the highest set bit of Pa.
- If Pa == 0: next state IDLE, Y_next = Y (hold).
REQ-017 Selection SHALL use P only, never same-cycle D; new requests become eligible one cycle after capture.
REQ-018 PRESENT with acc=0: Y and VLD SHALL hold stable, even if a higher-priority request becomes pending.
REQ-019 Latency: D sampled with EN=1 at edge k sets P at edge k; VLD=1 with that index no earlier than edge k+1.
REQ-020 Back-to-back: with RDY held high and several bits pending, one index SHALL be delivered per cycle with no bubble, in descending priority order.
REQ-021 A presented bit SHALL remain set in P until its transfer; PEND reflects P directly.
REQ-022 OVF_next = EN & |(D & P & ~clr); OVF SHALL be high for exactly one cycle per offending edge; the duplicate request is merged, not counted.
REQ-023 EN=0 SHALL NOT stop draining; pending requests continue to be presented and accepted.
REQ-024 RDY while VLD=0 SHALL have no effect.

Reset
REQ-025 rst=1 at a rising edge SHALL force P=4'b0000, Y=2'b00, VLD=0, OVF=0 and state IDLE, overriding all other inputs, including mid-transfer and same-cycle D.
REQ-026 The first edge after rst deasserts SHALL capture D normally when EN=1.

Verification
REQ-027 Reset, then EN=1, D=4'b0100 for one cycle, RDY=1 -> next edge PEND=0100; following edge VLD=1, Y=10; next edge VLD=0, PEND=0000.
REQ-028 EN=1, D=4'b1011 for one cycle, RDY=1 -> Y sequence 11, 01, 00 on consecutive cycles with VLD=1, then VLD=0 and PEND=0000.
REQ-029 Stall: pending 0001, VLD=1, Y=00, RDY=0; inject D=1000 -> Y stays 00 and PEND=1001; raise RDY -> Y=11 on the next cycle, then IDLE.
REQ-030 Overflow and re-queue: PEND=0010 and Y=01 accepted in the same cycle as EN=1, D=0110 -> OVF=0 and PEND=0110; with bit 2 pending and not being cleared, D=0100 -> OVF=1 for one cycle and PEND is unchanged.
REQ-031 EN=0 with D=1111 -> PEND unchanged; an existing pending 0010 still drains to Y=01.
REQ-032 Assert rst while VLD=1 and PEND=1110 with EN=1, D=0001 -> next edge PEND=0000, VLD=0, Y=00, OVF=0.

Source files
------------

// File: rtl/enc4to2_queue_if.sv
// Request/handshake bundle for the 4-to-2 request queue.
// The master drives requests and ready; the slave presents indices.
interface enc4to2_queue_if;
  logic       EN;
  logic [3:0] D;
  logic       RDY;
  logic [1:0] Y;
  logic       VLD;
  logic [3:0] PEND;
  logic       OVF;

  modport master (
    output EN,
    output D,
    output RDY,
    input  Y,
    input  VLD,
    input  PEND,
    input  OVF
  );

  modport slave (
    input  EN,
    input  D,
    input  RDY,
    output Y,
    output VLD,
    output PEND,
    output OVF
  );
endinterface

// File: rtl/enc4to2_queue.sv
// Priority request queue: merges multi-hot requests into a pending set
// and drains it as 2-bit indices over a valid/ready handshake.
module enc4to2_queue (
  input logic           clk,
  input logic           rst,
  enc4to2_queue_if.slave bus
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] p;
  logic [3:0] p_nx;
  logic [3:0] req;
  logic [3:0] clr;
  logic [3:0] pa;
  logic [1:0] y;
  logic [1:0] y_nx;
  logic [1:0] hi;
  logic       ovf;
  logic       ovf_nx;
  logic       vld;
  logic       acc;

  assign vld = (state == PRESENT);
  assign acc = vld & bus.RDY;
  assign req = bus.EN ? bus.D : 4'b0000;

  always_comb begin
    clr = 4'b0000;
    if (acc) begin
      unique case (y)
        2'd0: clr = 4'b0001;
        2'd1: clr = 4'b0010;
        2'd2: clr = 4'b0100;
        2'd3: clr = 4'b1000;
      endcase
    end
  end

  // set wins over clear, so a re-request of the accepted bit re-queues it
  assign pa     = p & ~clr;
  assign p_nx   = pa | req;
  assign ovf_nx = |(req & pa);

  always_comb begin
    hi = 2'd0;
    priority case (1'b1)
      pa[3]: hi = 2'd3;
      pa[2]: hi = 2'd2;
      pa[1]: hi = 2'd1;
      pa[0]: hi = 2'd0;
      default: hi = 2'd0;
    endcase
  end

  // a stalled presentation holds even if a higher bit becomes pending
  always_comb begin
    state_nx = state;
    y_nx     = y;
    if (state == IDLE || acc) begin
      if (|pa) begin
        state_nx = PRESENT;
        y_nx     = hi;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p     <= 4'b0000;
      y     <= 2'b00;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      p     <= p_nx;
      y     <= y_nx;
      ovf   <= ovf_nx;
    end
  end

  assign bus.Y    = y;
  assign bus.VLD  = vld;
  assign bus.PEND = p;
  assign bus.OVF  = ovf;

endmodule
